// File: rtl/dmem_if.sv
// Memory-stage to data-bus signal bundle shared by the pipeline, the access
// unit and the data bus.
interface dmem_if;
  logic        m_valid;
  logic        m_load;
  logic        m_store;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic        m_unsigned;
  logic [63:0] m_wdata;
  logic        m_advance;

  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;

  logic        data_ok;
  logic [63:0] dresp_data;

  logic        busy;
  logic [63:0] rdata;
  logic        misalign;

  // The access unit itself is the slave; pipeline/bus models drive the master side.
  modport slave (
    input  m_valid, m_load, m_store, m_addr, m_size, m_unsigned, m_wdata, m_advance,
    input  data_ok, dresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output busy, rdata, misalign
  );

  modport master (
    output m_valid, m_load, m_store, m_addr, m_size, m_unsigned, m_wdata, m_advance,
    output data_ok, dresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  busy, rdata, misalign
  );
endinterface

// File: rtl/dmem_access.sv
// Memory-stage data access unit: turns a load/store into a single aligned bus
// request, then aligns and extends the returned load data.
module dmem_access (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic [63:0] resp_q;
  logic        load_q;
  logic        unsigned_q;

  logic        access;
  logic        misalign;
  logic        mem_op;
  logic [2:0]  off;
  logic [63:0] align_mask;
  logic [7:0]  strobe_base;
  logic [7:0]  strobe_next;
  logic [63:0] wdata_shift;
  logic [63:0] resp_shift;
  logic [63:0] load_ext;

  assign off         = bus.m_addr[2:0];
  assign align_mask  = (64'd1 << bus.m_size) - 64'd1;
  assign access      = bus.m_valid & (bus.m_load | bus.m_store);
  assign misalign    = access & ((bus.m_addr & align_mask) != 64'd0);
  assign mem_op      = access & ~misalign;
  assign wdata_shift = bus.m_wdata << {off, 3'b000};

  always_comb begin
    strobe_base = 8'hFF;
    case (bus.m_size)
      3'd0:    strobe_base = 8'h01;
      3'd1:    strobe_base = 8'h03;
      3'd2:    strobe_base = 8'h0F;
      default: strobe_base = 8'hFF;
    endcase
    strobe_next = bus.m_store ? (strobe_base << off) : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op)        state_d = WAIT;
      WAIT:    if (bus.data_ok)   state_d = DONE;
      DONE:    if (bus.m_advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so the bus sees them stable for the whole WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 64'd0;
      size_q     <= 3'd0;
      strobe_q   <= 8'd0;
      wdata_q    <= 64'd0;
      resp_q     <= 64'd0;
      load_q     <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_op) begin
        addr_q     <= bus.m_addr;
        size_q     <= bus.m_size;
        strobe_q   <= strobe_next;
        wdata_q    <= wdata_shift;
        load_q     <= bus.m_load;
        unsigned_q <= bus.m_unsigned;
      end
      if (state_q == WAIT && bus.data_ok) begin
        resp_q <= bus.dresp_data;
      end
    end
  end

  assign resp_shift = resp_q >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = resp_shift;
    case (size_q)
      3'd0: load_ext = unsigned_q ? {56'd0, resp_shift[7:0]}
                                  : {{56{resp_shift[7]}}, resp_shift[7:0]};
      3'd1: load_ext = unsigned_q ? {48'd0, resp_shift[15:0]}
                                  : {{48{resp_shift[15]}}, resp_shift[15:0]};
      3'd2: load_ext = unsigned_q ? {32'd0, resp_shift[31:0]}
                                  : {{32{resp_shift[31]}}, resp_shift[31:0]};
      default: load_ext = resp_shift;
    endcase
  end

  // Reset gates the IDLE term so a live instruction cannot raise busy while held in reset.
  assign bus.busy        = ~reset & (((state_q == IDLE) & mem_op) | (state_q == WAIT));
  assign bus.misalign    = misalign;
  assign bus.dreq_valid  = (state_q == WAIT);
  assign bus.dreq_addr   = {addr_q[63:3], 3'b000};
  assign bus.dreq_size   = size_q;
  assign bus.dreq_strobe = strobe_q;
  assign bus.dreq_data   = wdata_q;
  assign bus.rdata       = (state_q == DONE && load_q) ? load_ext : 64'd0;

endmodule

// File: tb/tb_dmem_access.sv
// Directed scoreboard bench for dmem_access: stimulus pushes expected bus
// requests and load results, a negedge monitor pops and compares them.
module tb_dmem_access;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    int          cycles;
  } req_t;

  logic   clk;
  logic   reset;
  dmem_if bus ();

  req_t        req_q[$];
  logic [63:0] rdata_q[$];
  int          n_checks;
  int          n_fail;
  int          wait_cnt;
  bit          done_next;

  dmem_access dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every request cycle is checked against the oldest expected request.
  always @(negedge clk) begin
    if (reset) begin
      req_q.delete();
      wait_cnt  = 0;
      done_next = 1'b0;
    end else begin
      if (done_next) begin
        if (rdata_q.size() == 0) check_output("unexpected_done", 64'd1, 64'd0);
        else check_output("rdata_done", bus.rdata, rdata_q.pop_front());
        done_next = 1'b0;
      end
      if (bus.dreq_valid) begin
        if (req_q.size() == 0) begin
          check_output("unexpected_req", {63'd0, bus.dreq_valid}, 64'd0);
        end else begin
          check_output("dreq_addr",   bus.dreq_addr,          req_q[0].addr);
          check_output("dreq_size",   {61'd0, bus.dreq_size}, {61'd0, req_q[0].size});
          check_output("dreq_strobe", {56'd0, bus.dreq_strobe}, {56'd0, req_q[0].strobe});
          check_output("dreq_data",   bus.dreq_data,          req_q[0].data);
          wait_cnt++;
          if (bus.data_ok) begin
            check_output("req_cycles", 64'(wait_cnt), 64'(req_q[0].cycles));
            void'(req_q.pop_front());
            wait_cnt  = 0;
            done_next = 1'b1;
          end
        end
      end
    end
  end

  task automatic apply_stimulus(
    input logic        ld,
    input logic        st,
    input logic [63:0] addr,
    input logic [2:0]  size,
    input logic        uns,
    input logic [63:0] wdata,
    input logic [63:0] resp,
    input int          dok_delay,
    input int          adv_hold,
    input logic [63:0] exp_addr,
    input logic [7:0]  exp_strobe,
    input logic [63:0] exp_data,
    input logic [63:0] exp_rdata
  );
    req_t r;
    r.addr = exp_addr; r.size = size; r.strobe = exp_strobe;
    r.data = exp_data; r.cycles = dok_delay + 1;
    req_q.push_back(r);
    rdata_q.push_back(exp_rdata);
    @(posedge clk); #1;
    bus.m_valid = 1'b1; bus.m_load = ld; bus.m_store = st; bus.m_addr = addr;
    bus.m_size = size; bus.m_unsigned = uns; bus.m_wdata = wdata;
    bus.m_advance = 1'b0; bus.data_ok = 1'b0;
    @(negedge clk);
    check_output("busy_idle", {63'd0, bus.busy}, 64'd1);
    check_output("no_req_idle", {63'd0, bus.dreq_valid}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < dok_delay; i++) begin
      @(negedge clk);
      check_output("busy_wait", {63'd0, bus.busy}, 64'd1);
      @(posedge clk); #1;
    end
    bus.data_ok = 1'b1; bus.dresp_data = resp;
    @(negedge clk);
    check_output("busy_wait_ok", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1;
    // A stray data_ok while holding in DONE must be ignored.
    bus.dresp_data = ~resp;
    bus.data_ok = (adv_hold > 0);
    for (int i = 0; i < adv_hold; i++) begin
      @(negedge clk);
      check_output("busy_hold", {63'd0, bus.busy}, 64'd0);
      check_output("no_reissue", {63'd0, bus.dreq_valid}, 64'd0);
      check_output("rdata_hold", bus.rdata, exp_rdata);
      @(posedge clk); #1;
    end
    bus.data_ok = 1'b0; bus.m_advance = 1'b1;
    @(negedge clk);
    check_output("busy_done", {63'd0, bus.busy}, 64'd0);
    check_output("rdata_adv", bus.rdata, exp_rdata);
    @(posedge clk); #1;
    bus.m_valid = 1'b0; bus.m_load = 1'b0; bus.m_store = 1'b0; bus.m_advance = 1'b0;
    @(negedge clk);
    check_output("rdata_idle", bus.rdata, 64'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; wait_cnt = 0; done_next = 1'b0;
    reset = 1'b1;
    bus.m_valid = 1'b1; bus.m_load = 1'b1; bus.m_store = 1'b0;
    bus.m_addr = 64'h1000; bus.m_size = 3'd3; bus.m_unsigned = 1'b0;
    bus.m_wdata = 64'd0; bus.m_advance = 1'b0;
    bus.data_ok = 1'b0; bus.dresp_data = 64'd0;

    @(negedge clk);
    check_output("rst_busy",   {63'd0, bus.busy},        64'd0);
    check_output("rst_valid",  {63'd0, bus.dreq_valid},  64'd0);
    check_output("rst_addr",   bus.dreq_addr,            64'd0);
    check_output("rst_strobe", {56'd0, bus.dreq_strobe}, 64'd0);
    check_output("rst_data",   bus.dreq_data,            64'd0);
    check_output("rst_rdata",  bus.rdata,                64'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.m_valid = 1'b0;

    // ld, st, addr, size, uns, wdata, resp, dok_delay, adv_hold, exp_addr, exp_strobe, exp_data, exp_rdata
    apply_stimulus(1, 0, 64'h1000, 3'd3, 0, 64'd0, 64'h8877665544332211, 0, 0,
                   64'h1000, 8'h00, 64'd0, 64'h8877665544332211);
    apply_stimulus(1, 0, 64'h1003, 3'd0, 0, 64'd0, 64'h0000000080000000, 0, 0,
                   64'h1000, 8'h00, 64'd0, 64'hFFFFFFFFFFFFFF80);
    apply_stimulus(0, 1, 64'h2006, 3'd1, 0, 64'hABCD, 64'h0, 4, 0,
                   64'h2000, 8'hC0, 64'hABCD000000000000, 64'd0);
    apply_stimulus(1, 0, 64'h1006, 3'd1, 1, 64'd0, 64'h8877665544332211, 1, 0,
                   64'h1000, 8'h00, 64'd0, 64'h0000000000008877);
    apply_stimulus(1, 0, 64'h1004, 3'd2, 0, 64'd0, 64'h8877665544332211, 0, 0,
                   64'h1000, 8'h00, 64'd0, 64'hFFFFFFFF88776655);
    apply_stimulus(0, 1, 64'h2001, 3'd0, 0, 64'h5A, 64'h0, 2, 0,
                   64'h2000, 8'h02, 64'h0000000000005A00, 64'd0);
    apply_stimulus(0, 1, 64'h2004, 3'd2, 0, 64'h12345678, 64'h0, 0, 0,
                   64'h2000, 8'hF0, 64'h1234567800000000, 64'd0);
    apply_stimulus(1, 0, 64'h1008, 3'd3, 0, 64'd0, 64'h0123456789ABCDEF, 0, 3,
                   64'h1008, 8'h00, 64'd0, 64'h0123456789ABCDEF);

    // Misaligned word load: no request, no stall, FSM stays idle.
    @(posedge clk); #1;
    bus.m_valid = 1'b1; bus.m_load = 1'b1; bus.m_addr = 64'h3002; bus.m_size = 3'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("misalign",    {63'd0, bus.misalign},   64'd1);
      check_output("mis_busy",    {63'd0, bus.busy},       64'd0);
      check_output("mis_no_req",  {63'd0, bus.dreq_valid}, 64'd0);
      @(posedge clk); #1;
    end
    bus.m_valid = 1'b0; bus.m_load = 1'b0;
    @(negedge clk);
    check_output("misalign_clear", {63'd0, bus.misalign}, 64'd0);

    // Reset in the middle of WAIT abandons the request.
    begin
      req_t r;
      r.addr = 64'h4000; r.size = 3'd3; r.strobe = 8'h00; r.data = 64'd0; r.cycles = 99;
      req_q.push_back(r);
    end
    @(posedge clk); #1;
    bus.m_valid = 1'b1; bus.m_load = 1'b1; bus.m_addr = 64'h4000; bus.m_size = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("pre_rst_valid", {63'd0, bus.dreq_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_output("rst_mid_valid", {63'd0, bus.dreq_valid}, 64'd0);
    check_output("rst_mid_busy",  {63'd0, bus.busy},       64'd0);
    check_output("rst_mid_rdata", bus.rdata,               64'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.m_valid = 1'b0; bus.m_load = 1'b0;
    bus.data_ok = 1'b1; bus.dresp_data = 64'hDEADBEEFCAFEF00D;
    @(negedge clk);
    check_output("late_ok_valid", {63'd0, bus.dreq_valid}, 64'd0);
    check_output("late_ok_busy",  {63'd0, bus.busy},       64'd0);
    @(posedge clk); #1;
    bus.data_ok = 1'b0;
    @(negedge clk);
    check_output("late_ok_rdata", bus.rdata,               64'd0);
    check_output("late_ok_idle",  {63'd0, bus.dreq_valid}, 64'd0);

    @(posedge clk); #1;
    @(negedge clk);
    check_output("req_q_empty",   64'(req_q.size()),   64'd0);
    check_output("rdata_q_empty", 64'(rdata_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
